// File: rtl/tl_probe_fanout.sv
// rtl/tl_probe_fanout.sv - probe multicast engine between L2 directory and client B/C ports
// Optional watchdog: define TL_PROBE_TIMEOUT_EN to enable the TIMEOUT_CYCLES limit.
module tl_probe_fanout #(
  parameter int N_CLIENTS      = 4,
  parameter int CID_W          = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1,
  parameter int ADDR_W         = 64,
  parameter int SOURCE_W       = 4,
  parameter int M_SOURCE_W     = SOURCE_W + CID_W,
  parameter int LINE_LG        = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_W-1:0]     req_address_i,
  input  logic [2:0]            req_param_i,
  input  logic [SOURCE_W-1:0]   req_source_i,
  input  logic [N_CLIENTS-1:0]  req_sharers_i,
  output logic                  mgr_b_valid_o,
  input  logic                  mgr_b_ready_i,
  output logic [2:0]            mgr_b_opcode_o,
  output logic [2:0]            mgr_b_param_o,
  output logic [3:0]            mgr_b_size_o,
  output logic [SOURCE_W-1:0]   mgr_b_source_o,
  output logic [ADDR_W-1:0]     mgr_b_address_o,
  output logic [7:0]            mgr_b_mask_o,
  output logic [63:0]           mgr_b_data_o,
  output logic                  mgr_b_corrupt_o,
  output logic [CID_W-1:0]      mgr_b_dest_o,
  input  logic                  ack_valid_i,
  output logic                  ack_ready_o,
  input  logic [2:0]            ack_opcode_i,
  input  logic [M_SOURCE_W-1:0] ack_source_i,
  input  logic                  ack_last_i,
  output logic                  done_valid_o,
  input  logic                  done_ready_i,
  output logic [N_CLIENTS-1:0]  done_acked_o,
  output logic                  done_dirty_o,
  output logic                  done_timeout_o,
  output logic                  err_unexpected_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0]    addr_q;
  logic [2:0]           param_q;
  logic [SOURCE_W-1:0]  source_q;
  logic [N_CLIENTS-1:0] issue_mask, ack_pend, acked;
  logic                 dirty, err_q, timeout_fire;

  logic                 req_hs, b_hs, ack_hs, counted, unexpected;
  logic [N_CLIENTS-1:0] issue_bit, ack_oh, counted_oh, issue_nxt, pend_nxt;
  logic [CID_W-1:0]     ack_cid, b_dest;

  // Handshake readiness decodes from state; reset masks it so nothing is accepted mid-reset.
  assign req_ready_o   = !rst && (state_q == IDLE);
  assign mgr_b_valid_o = !rst && (state_q == ISSUE);
  assign done_valid_o  = !rst && (state_q == DONE);
  assign ack_ready_o   = !rst;

  assign req_hs = req_valid_i && req_ready_o;
  assign b_hs   = mgr_b_valid_o && mgr_b_ready_i;
  assign ack_hs = ack_valid_i && ack_ready_o;

  // Lowest pending sharer is the next probe target; depends only on registered state.
  assign issue_bit = issue_mask & ~(issue_mask - 1'b1);
  always_comb begin
    b_dest = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (issue_mask[i]) b_dest = CID_W'(i);
    end
  end

  // Decode the acking client; out-of-range IDs match no client and so count as unexpected.
  assign ack_cid = ack_source_i[M_SOURCE_W-1 -: CID_W];
  always_comb begin
    ack_oh = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (ack_cid == CID_W'(i)) ack_oh[i] = 1'b1;
    end
  end

  // Only last beats from a client with an outstanding probe complete it; the pending bit
  // is sampled before this cycle's B handshake, so a same-cycle ack is unexpected.
  assign counted_oh = ack_oh & ack_pend & {N_CLIENTS{ack_hs && ack_last_i}};
  assign counted    = |counted_oh;
  assign unexpected = ack_hs && ack_last_i && !counted;
  assign issue_nxt  = issue_mask & ~(b_hs ? issue_bit : '0);
  assign pend_nxt   = (ack_pend | (b_hs ? issue_bit : '0)) & ~counted_oh;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; WAIT leaves in the same cycle the final pending bit clears.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_hs) state_d = (req_sharers_i == '0) ? DONE : ISSUE;
      ISSUE:   if (issue_nxt == '0) state_d = WAIT;
      WAIT:    if (pend_nxt == '0) state_d = DONE;
      DONE:    if (done_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout_fire) state_d = DONE;
  end

  // Transaction context, issue/pending/acked masks and the unexpected-ack pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      param_q    <= '0;
      source_q   <= '0;
      issue_mask <= '0;
      ack_pend   <= '0;
      acked      <= '0;
      dirty      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= unexpected;
      if (req_hs) begin
        addr_q     <= req_address_i;
        param_q    <= req_param_i;
        source_q   <= req_source_i;
        issue_mask <= req_sharers_i;
        ack_pend   <= '0;
        acked      <= '0;
        dirty      <= 1'b0;
      end else if (timeout_fire) begin
        issue_mask <= '0;
        ack_pend   <= '0;
      end else begin
        issue_mask <= issue_nxt;
        ack_pend   <= pend_nxt;
        acked      <= acked | counted_oh;
        if (counted && ack_opcode_i == 3'd5) dirty <= 1'b1;
      end
    end
  end

`ifdef TL_PROBE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog;
  logic            timeout_q;
  logic            busy;

  assign busy         = (state_q == ISSUE) || (state_q == WAIT);
  assign timeout_fire = busy && !counted && (wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts cycles since the last counted ack (or since the probe started).
  always_ff @(posedge clk) begin
    if (rst || !busy) wdog <= '0;
    else if (counted) wdog <= WD_W'(1);
    else              wdog <= wdog + 1'b1;
  end

  // Timeout flag is part of the completion record, cleared by the next request.
  always_ff @(posedge clk) begin
    if (rst)               timeout_q <= 1'b0;
    else if (req_hs)       timeout_q <= 1'b0;
    else if (timeout_fire) timeout_q <= 1'b1;
  end

  assign done_timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_fire       = 1'b0;
  assign done_timeout_o     = 1'b0;
`endif

  logic unused_ack_src;
  assign unused_ack_src = ^ack_source_i[SOURCE_W-1:0];

  assign mgr_b_opcode_o   = 3'd6;
  assign mgr_b_param_o    = param_q;
  assign mgr_b_size_o     = 4'(LINE_LG);
  assign mgr_b_source_o   = source_q;
  assign mgr_b_address_o  = addr_q;
  assign mgr_b_mask_o     = 8'hFF;
  assign mgr_b_data_o     = 64'd0;
  assign mgr_b_corrupt_o  = 1'b0;
  assign mgr_b_dest_o     = b_dest;
  assign done_acked_o     = acked;
  assign done_dirty_o     = dirty;
  assign err_unexpected_o = err_q;

endmodule

// File: tb/tb_tl_probe_fanout.sv
// tb/tb_tl_probe_fanout.sv - table-driven bench for tl_probe_fanout
module tb_tl_probe_fanout;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid_i, req_ready_o;
  logic [63:0] req_address_i;
  logic [2:0]  req_param_i;
  logic [3:0]  req_source_i;
  logic [3:0]  req_sharers_i;
  logic        mgr_b_valid_o, mgr_b_ready_i;
  logic [2:0]  mgr_b_opcode_o, mgr_b_param_o;
  logic [3:0]  mgr_b_size_o, mgr_b_source_o;
  logic [63:0] mgr_b_address_o;
  logic [7:0]  mgr_b_mask_o;
  logic [63:0] mgr_b_data_o;
  logic        mgr_b_corrupt_o;
  logic [1:0]  mgr_b_dest_o;
  logic        ack_valid_i, ack_ready_o;
  logic [2:0]  ack_opcode_i;
  logic [5:0]  ack_source_i;
  logic        ack_last_i;
  logic        done_valid_o, done_ready_i;
  logic [3:0]  done_acked_o;
  logic        done_dirty_o, done_timeout_o, err_unexpected_o;

  tl_probe_fanout #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_address_i(req_address_i), .req_param_i(req_param_i),
    .req_source_i(req_source_i), .req_sharers_i(req_sharers_i),
    .mgr_b_valid_o(mgr_b_valid_o), .mgr_b_ready_i(mgr_b_ready_i),
    .mgr_b_opcode_o(mgr_b_opcode_o), .mgr_b_param_o(mgr_b_param_o),
    .mgr_b_size_o(mgr_b_size_o), .mgr_b_source_o(mgr_b_source_o),
    .mgr_b_address_o(mgr_b_address_o), .mgr_b_mask_o(mgr_b_mask_o),
    .mgr_b_data_o(mgr_b_data_o), .mgr_b_corrupt_o(mgr_b_corrupt_o),
    .mgr_b_dest_o(mgr_b_dest_o),
    .ack_valid_i(ack_valid_i), .ack_ready_o(ack_ready_o),
    .ack_opcode_i(ack_opcode_i), .ack_source_i(ack_source_i),
    .ack_last_i(ack_last_i),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .done_acked_o(done_acked_o), .done_dirty_o(done_dirty_o),
    .done_timeout_o(done_timeout_o), .err_unexpected_o(err_unexpected_o)
  );

  typedef struct {
    logic       r;
    logic       rv;
    logic [3:0] sh;
    logic       br;
    logic       av;
    logic [1:0] ac;
    logic [2:0] op;
    logic       al;
    logic       dr;
    logic       erq;
    logic       ebv;
    logic [1:0] ed;
    logic       edv;
    logic       cd;
    logic [3:0] ea;
    logic       edi;
    logic       eer;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [63:0] ADDR = 64'h0000_1234_5678_9AC0;

  function automatic vec_t mk(input logic r, input logic rv, input logic [3:0] sh,
                              input logic br, input logic av, input logic [1:0] ac,
                              input logic [2:0] op, input logic al, input logic dr,
                              input logic erq, input logic ebv, input logic [1:0] ed,
                              input logic edv, input logic cd, input logic [3:0] ea,
                              input logic edi, input logic eer);
    vec_t v;
    v.r = r; v.rv = rv; v.sh = sh; v.br = br; v.av = av; v.ac = ac; v.op = op;
    v.al = al; v.dr = dr; v.erq = erq; v.ebv = ebv; v.ed = ed; v.edv = edv;
    v.cd = cd; v.ea = ea; v.edi = edi; v.eer = eer;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    rst = 1'b0; req_valid_i = 1'b0; req_sharers_i = 4'b0; mgr_b_ready_i = 1'b0;
    ack_valid_i = 1'b0; ack_source_i = 6'd0; ack_opcode_i = 3'd4; ack_last_i = 1'b0;
    done_ready_i = 1'b0;
  endtask

  task automatic send_ack(input logic [1:0] c, input logic [2:0] op, input logic last);
    ack_valid_i = 1'b1; ack_source_i = {c, 4'h0}; ack_opcode_i = op; ack_last_i = last;
  endtask

  initial begin
    int k;
    idle_inputs();
    rst = 1'b1;
    req_address_i = ADDR; req_param_i = 3'd1; req_source_i = 4'hA;
    tick(); tick();

    //        r rv sh      br av ac op al dr | erq ebv ed edv cd ea      edi eer
    tbl.push_back(mk(1,0,4'b0000,0,0,0,4,0,0, 0,0,0,0,1,4'b0000,0,0));
    tbl.push_back(mk(0,0,4'b0000,0,0,0,4,0,0, 1,0,0,0,1,4'b0000,0,0));
    tbl.push_back(mk(0,1,4'b1011,1,0,0,4,0,0, 1,0,0,0,0,4'b0000,0,0));
    tbl.push_back(mk(0,0,4'b0000,1,0,0,4,0,0, 0,1,0,0,0,4'b0000,0,0));
    tbl.push_back(mk(0,0,4'b0000,1,0,0,4,0,0, 0,1,1,0,0,4'b0000,0,0));
    tbl.push_back(mk(0,0,4'b0000,1,0,0,4,0,0, 0,1,3,0,0,4'b0000,0,0));
    tbl.push_back(mk(0,0,4'b0000,0,1,3,4,1,0, 0,0,0,0,0,4'b0000,0,0));
    tbl.push_back(mk(0,0,4'b0000,0,1,0,4,1,0, 0,0,0,0,0,4'b0000,0,0));
    tbl.push_back(mk(0,0,4'b0000,0,1,1,4,1,0, 0,0,0,0,0,4'b0000,0,0));
    tbl.push_back(mk(0,0,4'b0000,0,1,1,4,1,0, 0,0,0,1,1,4'b1011,0,0));
    tbl.push_back(mk(0,0,4'b0000,0,0,0,4,0,1, 0,0,0,1,1,4'b1011,0,1));
    tbl.push_back(mk(0,1,4'b0000,0,0,0,4,0,0, 1,0,0,0,0,4'b0000,0,0));
    tbl.push_back(mk(0,0,4'b0000,0,0,0,4,0,1, 0,0,0,1,1,4'b0000,0,0));
    tbl.push_back(mk(0,1,4'b0011,1,0,0,4,0,0, 1,0,0,0,0,4'b0000,0,0));
    tbl.push_back(mk(0,0,4'b0000,1,0,0,4,0,0, 0,1,0,0,0,4'b0000,0,0));
    tbl.push_back(mk(0,0,4'b0000,1,0,0,4,0,0, 0,1,1,0,0,4'b0000,0,0));
    tbl.push_back(mk(0,0,4'b0000,0,1,1,5,1,0, 0,0,0,0,0,4'b0000,0,0));
    tbl.push_back(mk(0,0,4'b0000,0,1,1,4,1,0, 0,0,0,0,0,4'b0000,0,0));
    tbl.push_back(mk(0,0,4'b0000,0,0,0,4,0,0, 0,0,0,0,0,4'b0000,0,1));
    tbl.push_back(mk(0,0,4'b0000,0,1,2,4,1,0, 0,0,0,0,0,4'b0000,0,0));
    tbl.push_back(mk(0,0,4'b0000,0,1,0,4,1,0, 0,0,0,0,0,4'b0000,0,1));
    tbl.push_back(mk(0,0,4'b0000,0,0,0,4,0,1, 0,0,0,1,1,4'b0011,1,0));
    tbl.push_back(mk(0,0,4'b0000,0,0,0,4,0,0, 1,0,0,0,0,4'b0000,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; req_valid_i = tbl[i].rv; req_sharers_i = tbl[i].sh;
      mgr_b_ready_i = tbl[i].br; ack_valid_i = tbl[i].av; ack_source_i = {tbl[i].ac, 4'h0};
      ack_opcode_i = tbl[i].op; ack_last_i = tbl[i].al; done_ready_i = tbl[i].dr;
      #1;
      chk($sformatf("row%0d req_ready", i), req_ready_o, tbl[i].erq);
      chk($sformatf("row%0d ack_ready", i), ack_ready_o, !tbl[i].r);
      chk($sformatf("row%0d b_valid", i), mgr_b_valid_o, tbl[i].ebv);
      if (tbl[i].ebv) chk($sformatf("row%0d b_dest", i), mgr_b_dest_o, tbl[i].ed);
      chk($sformatf("row%0d done_valid", i), done_valid_o, tbl[i].edv);
      if (tbl[i].cd) begin
        chk($sformatf("row%0d done_acked", i), done_acked_o, tbl[i].ea);
        chk($sformatf("row%0d done_dirty", i), done_dirty_o, tbl[i].edi);
        chk($sformatf("row%0d done_timeout", i), done_timeout_o, 1'b0);
      end
      chk($sformatf("row%0d err_unexpected", i), err_unexpected_o, tbl[i].eer);
      tick();
    end

    // B stall: probe fields must hold for 5 cycles while ready is low.
    idle_inputs();
    req_valid_i = 1'b1; req_sharers_i = 4'b0100;
    #1; chk("stall accept", req_ready_o, 1'b1);
    tick();
    req_valid_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall b_valid", mgr_b_valid_o, 1'b1);
      chk("stall dest", mgr_b_dest_o, 2'd2);
      chk("stall opcode", mgr_b_opcode_o, 3'd6);
      chk("stall param", mgr_b_param_o, 3'd1);
      chk("stall size", mgr_b_size_o, 4'd6);
      chk("stall source", mgr_b_source_o, 4'hA);
      chk("stall address", mgr_b_address_o, ADDR);
      chk("stall mask/data/corrupt", {mgr_b_mask_o, mgr_b_data_o[7:0], 7'd0, mgr_b_corrupt_o},
          {8'hFF, 8'h00, 8'h00});
      tick();
    end
    mgr_b_ready_i = 1'b1;
    #1; chk("stall release b_valid", mgr_b_valid_o, 1'b1);
    tick();
    mgr_b_ready_i = 1'b0;
    send_ack(2'd2, 3'd5, 1'b0);
    #1; chk("wait b idle", mgr_b_valid_o, 1'b0);
    tick();
    send_ack(2'd2, 3'd5, 1'b1);
    #1; chk("beat1 ignored done_valid", done_valid_o, 1'b0);
    tick();
    ack_valid_i = 1'b0; ack_last_i = 1'b0;
    #1;
    chk("data done_valid", done_valid_o, 1'b1);
    chk("data acked", done_acked_o, 4'b0100);
    chk("data dirty", done_dirty_o, 1'b1);
    chk("data timeout", done_timeout_o, 1'b0);
    chk("data no err", err_unexpected_o, 1'b0);

    // Done held under backpressure.
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("hold done", {done_valid_o, done_acked_o, done_dirty_o, req_ready_o},
          {1'b1, 4'b0100, 1'b1, 1'b0});
      tick();
    end
    done_ready_i = 1'b1;
    tick();
    done_ready_i = 1'b0;

    // Reset during WAIT aborts the transaction; the late ack is unexpected.
    req_valid_i = 1'b1; req_sharers_i = 4'b0001; mgr_b_ready_i = 1'b1;
    #1; chk("abort accept", req_ready_o, 1'b1);
    tick();
    req_valid_i = 1'b0;
    #1; chk("abort probe", mgr_b_valid_o, 1'b1);
    tick();
    mgr_b_ready_i = 1'b0;
    #1; chk("abort in wait", {mgr_b_valid_o, req_ready_o, done_valid_o}, 3'b000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1; chk("abort idle", {req_ready_o, ack_ready_o, done_valid_o}, 3'b110);
    send_ack(2'd0, 3'd4, 1'b1);
    tick();
    ack_valid_i = 1'b0; ack_last_i = 1'b0;
    #1; chk("abort late ack err", err_unexpected_o, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort no done", {done_valid_o, req_ready_o}, 2'b01);
    end

`ifdef TL_PROBE_TIMEOUT_EN
    // Client 2 never answers; watchdog closes the transaction.
    req_valid_i = 1'b1; req_sharers_i = 4'b1111; mgr_b_ready_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    mgr_b_ready_i = 1'b0;
    send_ack(2'd3, 3'd4, 1'b1); tick();
    send_ack(2'd0, 3'd4, 1'b1); tick();
    send_ack(2'd1, 3'd4, 1'b1); tick();
    ack_valid_i = 1'b0; ack_last_i = 1'b0;
    k = 1;
    while (!done_valid_o && k < 40) begin
      tick();
      k++;
    end
    chk("timeout latency", k, 16);
    chk("timeout acked", done_acked_o, 4'b1011);
    chk("timeout flag", done_timeout_o, 1'b1);
    done_ready_i = 1'b1;
    tick();
    done_ready_i = 1'b0;
    send_ack(2'd2, 3'd4, 1'b1);
    tick();
    ack_valid_i = 1'b0; ack_last_i = 1'b0;
    chk("timeout late ack err", err_unexpected_o, 1'b1);
`else
    k = 0;
    chk("no timeout flag", done_timeout_o, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
